// File: rtl/pu_or1k_bp_update_scheduler_pkg.sv
// Shared types for the branch-predictor update scheduler:
// FSM states, 2-bit counter encodings and the pending-update entry.
package pu_or1k_bp_update_scheduler_pkg;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    UPD_RD,
    UPD_WR
  } bp_state_e;

  localparam logic [1:0] CNT_SNT = 2'd0;
  localparam logic [1:0] CNT_WNT = 2'd1;
  localparam logic [1:0] CNT_WT  = 2'd2;
  localparam logic [1:0] CNT_ST  = 2'd3;

  // Entry index is sized for the widest table we support.
  localparam int BP_IDX_MAX_W = 16;

  typedef struct packed {
    logic [BP_IDX_MAX_W-1:0] idx;
    logic                    taken;
  } bp_upd_t;

  localparam int BP_UPD_W = $bits(bp_upd_t);

  function automatic logic [1:0] bp_sat_update(
    input logic [1:0] c,
    input logic       taken
  );
    logic [1:0] r;
    if (taken) begin
      r = (c == CNT_ST) ? CNT_ST : c + 2'd1;
    end else begin
      r = (c == CNT_SNT) ? CNT_SNT : c - 2'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pu_or1k_bp_update_scheduler_fifo.sv
// Pending-update FIFO: registered wrap-bit pointers,
// full/empty flags, simultaneous push+pop allowed when full.
module pu_or1k_bp_update_fifo
  import pu_or1k_bp_update_scheduler_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push_i,
  input  logic [BP_UPD_W-1:0] din_i,
  input  logic                pop_i,
  output logic [BP_UPD_W-1:0] dout_o,
  output logic                full_o,
  output logic                empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]         wr_ptr_q, wr_ptr_d;
  logic [AW:0]         rd_ptr_q, rd_ptr_d;
  logic [BP_UPD_W-1:0] mem_q [DEPTH];
  logic                do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign dout_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/pu_or1k_bp_update_scheduler.sv
// Schedules 2-bit predictor counter updates onto a single-port
// table RAM shared with decode-stage lookups, with anti-starvation.
module pu_or1k_bp_update_scheduler
  import pu_or1k_bp_update_scheduler_pkg::*;
#(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int TABLE_INDEX_WIDTH    = 6,
  parameter int FIFO_DEPTH           = 4,
  parameter int STARVE_LIMIT         = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            resolve_valid_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] resolve_pc_i,
  input  logic                            resolve_taken_i,
  output logic                            resolve_ready_o,
  output logic                            drop_o,
  input  logic                            lookup_req_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] lookup_pc_i,
  output logic                            lookup_gnt_o,
  output logic                            lookup_rvalid_o,
  output logic [1:0]                      lookup_counter_o,
  output logic                            table_en_o,
  output logic                            table_we_o,
  output logic [TABLE_INDEX_WIDTH-1:0]    table_addr_o,
  output logic [1:0]                      table_wdata_o,
  input  logic [1:0]                      table_rdata_i,
  output logic                            init_done_o
);

  localparam int IW = TABLE_INDEX_WIDTH;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [IW-1:0] LAST_ADDR  = '1;

  bp_state_e     state_q, state_d;
  logic [IW-1:0] init_addr_q, init_addr_d;
  logic          init_done_q, init_done_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          rvalid_q, rvalid_d;

  logic [IW-1:0]       rs_idx, lk_idx, head_idx;
  bp_upd_t             push_ent, head_ent;
  logic [BP_UPD_W-1:0] head_raw;
  logic                fifo_full, fifo_empty;
  logic                push, pop, ready;
  logic                upd_req, upd_win, lk_win, init_wr;
  logic                unused_w;

  assign rs_idx   = resolve_pc_i[IW+1:2];
  assign lk_idx   = lookup_pc_i[IW+1:2];
  assign push_ent = '{idx: BP_IDX_MAX_W'(rs_idx),
                      taken: resolve_taken_i};
  assign head_ent = bp_upd_t'(head_raw);
  assign head_idx = head_ent.idx[IW-1:0];
  assign unused_w = ^{resolve_pc_i, lookup_pc_i, head_ent.idx};

  assign init_wr = !rst && (state_q == INIT);
  assign upd_req = (state_q == UPD_RD) || (state_q == UPD_WR);

  // Lookups own the port until the update has been starved long enough.
  assign lk_win  = !rst && lookup_req_i && (state_q != INIT) &&
                   !(upd_req && (starve_q == STARVE_MAX));
  assign upd_win = !rst && upd_req && !lk_win;
  assign pop     = upd_win && (state_q == UPD_WR);

  assign ready = rst || !fifo_full || pop;
  assign push  = !rst && resolve_valid_i && ready;

  assign resolve_ready_o  = ready;
  assign drop_o           = !rst && resolve_valid_i && !ready;
  assign lookup_gnt_o     = lk_win;
  assign lookup_rvalid_o  = rvalid_q && !rst;
  assign lookup_counter_o = lookup_rvalid_o ? table_rdata_i : 2'b00;
  assign init_done_o      = init_done_q && !rst;

  pu_or1k_bp_update_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (BP_UPD_W'(push_ent)),
    .pop_i   (pop),
    .dout_o  (head_raw),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    table_en_o    = 1'b0;
    table_we_o    = 1'b0;
    table_addr_o  = '0;
    table_wdata_o = 2'b00;
    unique case (1'b1)
      init_wr: begin
        table_en_o    = 1'b1;
        table_we_o    = 1'b1;
        table_addr_o  = init_addr_q;
        table_wdata_o = CNT_WNT;
      end
      lk_win: begin
        table_en_o   = 1'b1;
        table_addr_o = lk_idx;
      end
      upd_win: begin
        table_en_o   = 1'b1;
        table_addr_o = head_idx;
        if (state_q == UPD_WR) begin
          table_we_o    = 1'b1;
          table_wdata_o = bp_sat_update(table_rdata_i,
                                        head_ent.taken);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    init_done_d = init_done_q;
    starve_d    = starve_q;
    rvalid_d    = lk_win;
    if (upd_win) begin
      starve_d = '0;
    end else if (upd_req && lk_win) begin
      starve_d = starve_q + SW'(1);
    end
    unique case (state_q)
      INIT: begin
        if (init_addr_q == LAST_ADDR) begin
          state_d     = IDLE;
          init_done_d = 1'b1;
        end else begin
          init_addr_d = init_addr_q + IW'(1);
        end
      end
      IDLE: begin
        if (!fifo_empty) state_d = UPD_RD;
      end
      UPD_RD: begin
        if (upd_win) state_d = UPD_WR;
      end
      UPD_WR: begin
        // A preempted write lost its read data: re-read.
        state_d = upd_win ? IDLE : UPD_RD;
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT;
      init_addr_q <= '0;
      init_done_q <= 1'b0;
      starve_q    <= '0;
      rvalid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      init_done_q <= init_done_d;
      starve_q    <= starve_d;
      rvalid_q    <= rvalid_d;
    end
  end

endmodule

// File: tb/tb_pu_or1k_bp_update_scheduler.sv
// Directed table-driven bench for the predictor update scheduler,
// with a behavioural 1-cycle-latency table RAM.
module tb_pu_or1k_bp_update_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        resolve_valid;
  logic [31:0] resolve_pc;
  logic        resolve_taken;
  logic        resolve_ready;
  logic        drop;
  logic        lookup_req;
  logic [31:0] lookup_pc;
  logic        lookup_gnt;
  logic        lookup_rvalid;
  logic [1:0]  lookup_counter;
  logic        table_en;
  logic        table_we;
  logic [5:0]  table_addr;
  logic [1:0]  table_wdata;
  logic        init_done;

  logic [1:0] ram [64] = '{default: 2'b11};
  logic [1:0] ram_rdata = 2'b00;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        rtk;
    logic        lreq;
    logic [31:0] lpc;
    logic [15:0] exp;
  } vec_t;

  vec_t tv[$];

  always #5 clk = ~clk;

  pu_or1k_bp_update_scheduler dut (
    .clk              (clk),
    .rst              (rst),
    .resolve_valid_i  (resolve_valid),
    .resolve_pc_i     (resolve_pc),
    .resolve_taken_i  (resolve_taken),
    .resolve_ready_o  (resolve_ready),
    .drop_o           (drop),
    .lookup_req_i     (lookup_req),
    .lookup_pc_i      (lookup_pc),
    .lookup_gnt_o     (lookup_gnt),
    .lookup_rvalid_o  (lookup_rvalid),
    .lookup_counter_o (lookup_counter),
    .table_en_o       (table_en),
    .table_we_o       (table_we),
    .table_addr_o     (table_addr),
    .table_wdata_o    (table_wdata),
    .table_rdata_i    (ram_rdata),
    .init_done_o      (init_done)
  );

  always @(posedge clk) begin
    if (table_en) begin
      if (table_we) ram[table_addr] <= table_wdata;
      else ram_rdata <= ram[table_addr];
    end
  end

  function automatic vec_t mk(
    input logic rs, input logic rv, input logic [31:0] rpc,
    input logic rtk, input logic lreq, input logic [31:0] lpc,
    input logic rdy, input logic drp, input logic gnt,
    input logic rvl, input logic [1:0] cnt, input logic en,
    input logic we, input int addr, input logic [1:0] wd
  );
    vec_t v;
    v.rst  = rs;
    v.rv   = rv;
    v.rpc  = rpc;
    v.rtk  = rtk;
    v.lreq = lreq;
    v.lpc  = lpc;
    v.exp  = {rdy, drp, gnt, rvl, cnt, en, we, 6'(addr), wd};
    return v;
  endfunction

  function automatic logic [15:0] obs();
    return {resolve_ready, drop, lookup_gnt, lookup_rvalid,
            lookup_counter, table_en, table_we, table_addr,
            table_wdata};
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    rst           = v.rst;
    resolve_valid = v.rv;
    resolve_pc    = v.rpc;
    resolve_taken = v.rtk;
    lookup_req    = v.lreq;
    lookup_pc     = v.lpc;
  endtask

  task automatic idle_cycles(input int n);
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      apply(tv[i]);
      @(negedge clk);
      check($sformatf("row%0d", i), 32'(obs()), 32'(tv[i].exp));
      @(posedge clk);
      #1;
    end
  endtask

  // Called one cycle after the reset edge; covers 64 INIT writes
  // and the first IDLE cycle.
  task automatic init_seq(input bit push_mid);
    for (int c = 0; c < 64; c++) begin
      rst           = 1'b0;
      lookup_req    = 1'b1;
      lookup_pc     = 32'h44;
      resolve_valid = push_mid && (c == 10);
      resolve_pc    = 32'h104;
      resolve_taken = 1'b0;
      @(negedge clk);
      check($sformatf("init_wr%0d", c),
            {table_en, table_we, table_addr, table_wdata},
            {1'b1, 1'b1, 6'(c), 2'b01});
      check($sformatf("init_ctl%0d", c),
            {lookup_gnt, lookup_rvalid, init_done, resolve_ready, drop},
            5'b00010);
      @(posedge clk);
      #1;
    end
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    check("init_done", init_done, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  initial begin
    int bad;

    // Scenario A: entry 0 saturates upwards, then is looked up.
    tv.push_back(mk(0,1,'h100,1,0,0, 1,0,0,0,0,0,0,0,0));
    tv.push_back(mk(0,1,'h100,1,0,0, 1,0,0,0,0,0,0,0,0));
    tv.push_back(mk(0,0,0,0,0,0,     1,0,0,0,0,1,0,0,0));
    tv.push_back(mk(0,0,0,0,0,0,     1,0,0,0,0,1,1,0,2));
    tv.push_back(mk(0,0,0,0,0,0,     1,0,0,0,0,0,0,0,0));
    tv.push_back(mk(0,0,0,0,0,0,     1,0,0,0,0,1,0,0,0));
    tv.push_back(mk(0,0,0,0,0,0,     1,0,0,0,0,1,1,0,3));
    tv.push_back(mk(0,1,'h100,1,0,0, 1,0,0,0,0,0,0,0,0));
    tv.push_back(mk(0,0,0,0,0,0,     1,0,0,0,0,0,0,0,0));
    tv.push_back(mk(0,0,0,0,0,0,     1,0,0,0,0,1,0,0,0));
    tv.push_back(mk(0,0,0,0,0,0,     1,0,0,0,0,1,1,0,3));
    tv.push_back(mk(0,0,0,0,1,'h100, 1,0,1,0,0,1,0,0,0));
    tv.push_back(mk(0,0,0,0,0,0,     1,0,0,1,3,0,0,0,0));
    // Scenario B: starvation limit, then lookup preempts UPD_WR.
    tv.push_back(mk(0,1,'h108,1,1,'h0C, 1,0,1,0,0,1,0,3,0));
    tv.push_back(mk(0,0,0,0,1,'h0C,     1,0,1,1,1,1,0,3,0));
    tv.push_back(mk(0,0,0,0,1,'h0C,     1,0,1,1,1,1,0,3,0));
    tv.push_back(mk(0,0,0,0,1,'h0C,     1,0,1,1,1,1,0,3,0));
    tv.push_back(mk(0,0,0,0,1,'h0C,     1,0,1,1,1,1,0,3,0));
    tv.push_back(mk(0,0,0,0,1,'h0C,     1,0,0,1,1,1,0,2,0));
    tv.push_back(mk(0,0,0,0,1,'h0C,     1,0,1,0,0,1,0,3,0));
    tv.push_back(mk(0,0,0,0,0,0,        1,0,0,1,1,1,0,2,0));
    tv.push_back(mk(0,0,0,0,0,0,        1,0,0,0,0,1,1,2,2));
    tv.push_back(mk(0,0,0,0,0,0,        1,0,0,0,0,0,0,0,0));
    // Scenario C: FIFO fills under lookup pressure, fifth drops.
    tv.push_back(mk(0,1,'h110,1,1,0, 1,0,1,0,0,1,0,0,0));
    tv.push_back(mk(0,1,'h114,0,1,0, 1,0,1,1,3,1,0,0,0));
    tv.push_back(mk(0,1,'h118,1,1,0, 1,0,1,1,3,1,0,0,0));
    tv.push_back(mk(0,1,'h11C,0,1,0, 1,0,1,1,3,1,0,0,0));
    tv.push_back(mk(0,1,'h120,1,1,0, 0,1,1,1,3,1,0,0,0));
    tv.push_back(mk(0,0,0,0,1,0,     0,0,0,1,3,1,0,4,0));
    tv.push_back(mk(0,0,0,0,0,0,     1,0,0,0,0,1,1,4,2));
    // Scenario D: reset lands while in UPD_WR.
    tv.push_back(mk(0,1,'h124,1,0,0,    1,0,0,0,0,0,0,0,0));
    tv.push_back(mk(0,0,0,0,0,0,        1,0,0,0,0,0,0,0,0));
    tv.push_back(mk(0,0,0,0,0,0,        1,0,0,0,0,1,0,9,0));
    tv.push_back(mk(1,1,'h130,1,1,'h0C, 1,0,0,0,0,0,0,0,0));

    rst           = 1'b1;
    resolve_valid = 1'b1;
    resolve_pc    = 32'h104;
    resolve_taken = 1'b1;
    lookup_req    = 1'b1;
    lookup_pc     = 32'h0C;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_outputs",
          {init_done, lookup_gnt, lookup_rvalid, drop,
           table_we, table_en, resolve_ready},
          7'b0000001);
    @(posedge clk);
    #1;

    init_seq(1'b1);
    idle_cycles(6);
    check("init_push_idx1", ram[1], 2'b00);
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      if (i != 1 && ram[i] != 2'b01) bad++;
    end
    check("init_fill", bad, 0);

    run_rows(0, 22);
    check("a_entry0", ram[0], 2'd3);
    check("b_entry2", ram[2], 2'd2);

    run_rows(23, 29);
    idle_cycles(12);
    check("c_entry4", ram[4], 2'd2);
    check("c_entry5", ram[5], 2'd0);
    check("c_entry6", ram[6], 2'd2);
    check("c_entry7", ram[7], 2'd0);
    check("c_dropped8", ram[8], 2'd1);

    run_rows(30, 33);
    init_seq(1'b0);
    for (int i = 0; i < 4; i++) begin
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      check($sformatf("post_rst_idle%0d", i),
            {table_en, table_we}, 2'b00);
      @(posedge clk);
      #1;
    end
    check("d_entry9", ram[9], 2'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pu_or1k_bp_update_scheduler.md
PU_OR1K_BP_UPDATE_SCHEDULER -- requirements
Module: pu_or1k_bp_update_scheduler

Interface
REQ-001 SHALL have parameter OPTION_OPERAND_WIDTH, default 32, meaning PC width.
REQ-002 SHALL have parameter TABLE_INDEX_WIDTH, default 6, meaning counter-table index bits (2^W entries).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4 (power of two), meaning pending-update buffer entries.
REQ-004 SHALL have parameter STARVE_LIMIT, default 3, meaning the number of consecutive lookup-preempted cycles before an update wins.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have ports resolve_valid_i (in, 1), resolve_pc_i (in, OPTION_OPERAND_WIDTH) and resolve_taken_i (in, 1): the resolved conditional branch and its real flag.
REQ-008 SHALL have port resolve_ready_o, out, 1 bit: the FIFO can accept a push this cycle.
REQ-009 SHALL have port drop_o, out, 1 bit: one-cycle pulse when a resolve is lost.
REQ-010 SHALL have ports lookup_req_i (in, 1) and lookup_pc_i (in, OPTION_OPERAND_WIDTH): the prediction read request from the decode stage.
REQ-011 SHALL have ports lookup_gnt_o (out, 1), lookup_rvalid_o (out, 1) and lookup_counter_o (out, 2): grant, read-data valid, and the counter value.
REQ-012 SHALL have ports table_en_o (out, 1), table_we_o (out, 1), table_addr_o (out, TABLE_INDEX_WIDTH), table_wdata_o (out, 2) and table_rdata_i (in, 2): the single-port synchronous RAM with 1-cycle read latency.
REQ-013 SHALL have port init_done_o, out, 1 bit: table initialisation is complete.

Function
REQ-014 SHALL compute each table index as pc[TABLE_INDEX_WIDTH+1:2].
REQ-015 SHALL push {index, taken} into the FIFO when resolve_valid_i && resolve_ready_o.
REQ-016 SHALL drive resolve_ready_o = !full || pop_this_cycle; resolve_valid_i with resolve_ready_o low SHALL pulse drop_o and leave the FIFO unchanged.
REQ-017 SHALL use the FSM states INIT, IDLE, UPD_RD, UPD_WR.
REQ-018 INIT SHALL write 2'b01 (weakly not-taken) to addresses 0..2^W-1, one per cycle, then go to IDLE and set init_done_o; no lookup grants SHALL occur during INIT, but FIFO pushes SHALL be accepted.
REQ-019 IDLE SHALL go to UPD_RD when the FIFO is non-empty.
REQ-020 UPD_RD SHALL issue a read at the head index; when granted, the next state SHALL be UPD_WR.
REQ-021 UPD_WR SHALL write the saturating counter using table_rdata_i: taken means min(c+1,3), not-taken means max(c-1,0).
REQ-022 In UPD_WR, when the write is granted, the FIFO SHALL pop and the FSM SHALL go to IDLE.
REQ-023 Port arbitration each cycle: lookup_req_i SHALL win the port over UPD_RD/UPD_WR unless the starvation counter equals STARVE_LIMIT, in which case the update SHALL win.
REQ-024 The starvation counter SHALL increment on each preempted update cycle and clear when an update access is granted.
REQ-025 If a lookup preempts UPD_WR, the FSM SHALL return to UPD_RD, because the read data is lost.
REQ-026 lookup_gnt_o SHALL be combinational in the access cycle; lookup_rvalid_o SHALL assert exactly one cycle later with lookup_counter_o = table_rdata_i, and SHALL be 0 otherwise.
REQ-027 No forwarding between an in-flight update and a lookup to the same index; a stale read is architecturally tolerated.
REQ-028 When table_en_o is 0, table_we_o, table_addr_o and table_wdata_o SHALL all be 0.

Reset
REQ-029 rst SHALL force state INIT, the init address to 0, the FIFO to empty, and the starvation counter to 0.
REQ-030 During and after reset, init_done_o, lookup_gnt_o, lookup_rvalid_o, drop_o and table_we_o SHALL be 0, and resolve_ready_o SHALL be 1.
REQ-031 Reset mid-update SHALL discard pending updates and restart INIT from address 0.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, the counter constants (SNT=0, WNT=1, WT=2, ST=3), and the FIFO-entry struct.
REQ-033 The FIFO SHALL be a sub-module, pu_or1k_bp_update_fifo (synchronous, registered pointers, full/empty flags).

Verification
REQ-034 Reset then no stimulus -> 64 writes of 01 at addresses 0..63, then init_done_o=1 at cycle 65.
REQ-035 After init, resolve pc=0x100 taken twice -> entry 0 goes 01→10→11; a third taken leaves it 11; a lookup of 0x100 then returns 3.
REQ-036 Continuous lookup_req_i with one pending update -> the update is granted on the 4th cycle (STARVE_LIMIT=3) and the lookup is denied in that cycle.
REQ-037 Five resolves in consecutive cycles while lookups block updates -> first four accepted, fifth pulses drop_o with resolve_ready_o=0.
REQ-038 rst asserted in UPD_WR -> no write occurs, the FIFO empties, and INIT restarts at address 0.
